// File: rtl/watch_pkg.sv
// Shared encodings and timing constants for the watch mode controller.
package watch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_HOLD = 2'd2
  } sw_state_e;

  typedef enum logic {
    AL_OFF  = 1'b0,
    AL_RING = 1'b1
  } alarm_state_e;

  localparam int CLK_PER_MS = 5;
  localparam int MS_PER_SEC = 1000;
  localparam int RING_SECS  = 60;

endpackage

// File: rtl/watch_mode_controller_if.sv
// Button, alarm and status signals exchanged between the controller and its surroundings.
interface watch_mode_controller_if;

  logic Control;
  logic Start_S;
  logic Stop_S;
  logic Reset_S;
  logic AlarmEnable;
  logic AlarmMatch;
  logic MsTick;
  logic SecTick;
  logic SW_Run;
  logic SW_Clear;
  logic SW_State;
  logic Alarm;
  logic DispSel;

  modport master (
    output Control, Start_S, Stop_S, Reset_S, AlarmEnable, AlarmMatch,
    input  MsTick, SecTick, SW_Run, SW_Clear, SW_State, Alarm, DispSel
  );

  modport slave (
    input  Control, Start_S, Stop_S, Reset_S, AlarmEnable, AlarmMatch,
    output MsTick, SecTick, SW_Run, SW_Clear, SW_State, Alarm, DispSel
  );

endinterface

// File: rtl/watch_mode_controller_edge_detect.sv
// One-bit rising-edge detector; history resets to 1 so a level held through reset is not an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/watch_mode_controller.sv
// Watch controller: ms/s prescaler, stopwatch FSM and alarm FSM.
module watch_mode_controller
  import watch_pkg::*;
#(
  parameter int ClkPerMs = CLK_PER_MS,
  parameter int MsPerSec = MS_PER_SEC,
  parameter int RingSecs = RING_SECS
) (
  input  logic                    Clock_5K,
  input  logic                    Reset,
  watch_mode_controller_if.slave  bus
);

  localparam int MsW   = (ClkPerMs > 1) ? $clog2(ClkPerMs) : 1;
  localparam int SecW  = (MsPerSec > 1) ? $clog2(MsPerSec) : 1;
  localparam int RingW = (RingSecs > 1) ? $clog2(RingSecs) : 1;

  logic [MsW-1:0]   msCnt_q, msCnt_d;
  logic [SecW-1:0]  secCnt_q, secCnt_d;
  logic [RingW-1:0] ringCnt_q, ringCnt_d;
  logic             dispSel_q;
  logic             msTick, secTick;

  sw_state_e        swState_q, swState_d;
  logic             swClear_q, swClear_d;
  alarm_state_e     alState_q, alState_d;
  logic             swRun, alarm;

  logic startRise, stopRise, clearRise, matchRise;
  logic swStart, swStop, swClr, dismiss;

  edge_detect u_start (.clk(Clock_5K), .reset(Reset), .d_i(bus.Start_S),    .rise_o(startRise));
  edge_detect u_stop  (.clk(Clock_5K), .reset(Reset), .d_i(bus.Stop_S),     .rise_o(stopRise));
  edge_detect u_clear (.clk(Clock_5K), .reset(Reset), .d_i(bus.Reset_S),    .rise_o(clearRise));
  edge_detect u_match (.clk(Clock_5K), .reset(Reset), .d_i(bus.AlarmMatch), .rise_o(matchRise));

  // Stopwatch buttons act only in stopwatch mode; Stop in clock mode dismisses the alarm.
  assign swStart = startRise & ~bus.Control;
  assign swStop  = stopRise  & ~bus.Control;
  assign swClr   = clearRise & ~bus.Control;
  assign dismiss = stopRise  &  bus.Control;

  assign msTick  = (msCnt_q == MsW'(ClkPerMs - 1));
  assign secTick = msTick && (secCnt_q == SecW'(MsPerSec - 1));

  always_comb begin
    msCnt_d  = msTick ? '0 : msCnt_q + MsW'(1);
    secCnt_d = secCnt_q;
    if (msTick) secCnt_d = secTick ? '0 : secCnt_q + SecW'(1);
  end

  always_ff @(posedge Clock_5K) begin
    if (Reset) begin
      msCnt_q   <= '0;
      secCnt_q  <= '0;
      dispSel_q <= bus.Control;
    end else begin
      msCnt_q   <= msCnt_d;
      secCnt_q  <= secCnt_d;
      dispSel_q <= bus.Control;
    end
  end

  always_ff @(posedge Clock_5K) begin
    if (Reset) begin
      swState_q <= SW_IDLE;
      swClear_q <= 1'b0;
      alState_q <= AL_OFF;
      ringCnt_q <= '0;
    end else begin
      swState_q <= swState_d;
      swClear_q <= swClear_d;
      alState_q <= alState_d;
      ringCnt_q <= ringCnt_d;
    end
  end

  // Clear outranks Stop, which outranks Start, when edges coincide.
  always_comb begin
    swState_d = swState_q;
    swClear_d = 1'b0;
    case (swState_q)
      SW_IDLE: if (swStart) swState_d = SW_RUN;
      SW_RUN: begin
        if (swClr) begin
          swState_d = SW_IDLE;
          swClear_d = 1'b1;
        end else if (swStop) begin
          swState_d = SW_HOLD;
        end
      end
      SW_HOLD: begin
        if (swClr) begin
          swState_d = SW_IDLE;
          swClear_d = 1'b1;
        end else if (swStart) begin
          swState_d = SW_RUN;
        end
      end
      default: swState_d = SW_IDLE;
    endcase
  end

  always_comb begin
    alState_d = alState_q;
    ringCnt_d = ringCnt_q;
    case (alState_q)
      AL_OFF: begin
        ringCnt_d = '0;
        if (matchRise && bus.AlarmEnable) alState_d = AL_RING;
      end
      AL_RING: begin
        if (secTick) ringCnt_d = ringCnt_q + RingW'(1);
        if (!bus.AlarmEnable || dismiss ||
            (secTick && ringCnt_q == RingW'(RingSecs - 1))) begin
          alState_d = AL_OFF;
          ringCnt_d = '0;
        end
      end
      default: alState_d = AL_OFF;
    endcase
  end

  always_comb begin
    swRun = (swState_q == SW_RUN);
    alarm = (alState_q == AL_RING);
  end

  assign bus.MsTick   = msTick;
  assign bus.SecTick  = secTick;
  assign bus.SW_Run   = swRun;
  assign bus.SW_State = swRun;
  assign bus.SW_Clear = swClear_q;
  assign bus.Alarm    = alarm;
  assign bus.DispSel  = dispSel_q;

endmodule

// File: tb/tb_watch_mode_controller.sv
// Scoreboard bench: full-rate instance for tick timing, shortened-second instance for the FSMs.
module tb_watch_mode_controller;

  logic clk;
  logic Reset;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } item_t;

  item_t sb[$];
  int    secQ[$];

  watch_mode_controller_if ifA ();
  watch_mode_controller_if ifB ();

  watch_mode_controller dutA (
    .Clock_5K (clk),
    .Reset    (Reset),
    .bus      (ifA)
  );

  watch_mode_controller #(
    .ClkPerMs (5),
    .MsPerSec (4),
    .RingSecs (60)
  ) dutB (
    .Clock_5K (clk),
    .Reset    (Reset),
    .bus      (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input logic rst, input logic ctrl, input logic st,
                             input logic sp, input logic cl, input logic en,
                             input logic mt);
    Reset           = rst;
    ifA.Control     = ctrl; ifB.Control     = ctrl;
    ifA.Start_S     = st;   ifB.Start_S     = st;
    ifA.Stop_S      = sp;   ifB.Stop_S      = sp;
    ifA.Reset_S     = cl;   ifB.Reset_S     = cl;
    ifA.AlarmEnable = en;   ifB.AlarmEnable = en;
    ifA.AlarmMatch  = mt;   ifB.AlarmMatch  = mt;
  endtask

  // exp = {SW_State, SW_Clear, Alarm, DispSel}; SW_Run must track SW_State.
  task automatic applyStimulus(input string tag, input logic rst, input logic ctrl,
                               input logic st, input logic sp, input logic cl,
                               input logic en, input logic mt, input logic [3:0] exp);
    item_t it;
    driveInputs(rst, ctrl, st, sp, cl, en, mt);
    it.tag = tag;
    it.exp = {exp[3], exp};
    sb.push_back(it);
    @(negedge clk);
    it = sb.pop_front();
    checkOutput(it.tag, {27'd0, ifB.SW_Run, ifB.SW_State, ifB.SW_Clear, ifB.Alarm, ifB.DispSel},
                {27'd0, it.exp});
  endtask

  initial begin
    int msCount;
    int firstMs;
    int firstSec;
    int ringTicks;
    int n;

    checks = 0;
    errors = 0;
    driveInputs(1'b1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus("reset_state", 1, 0, 0, 0, 0, 0, 0, 4'b0000);
    checkOutput("reset_ticks", {30'd0, ifA.MsTick, ifA.SecTick}, 32'd0);

    // Full-rate prescaler: cycle 1 is the first cycle after reset was last sampled.
    driveInputs(1'b0, 0, 0, 0, 0, 0, 0);
    secQ.push_back(5000);
    secQ.push_back(10000);
    msCount = 0;
    firstMs = 0;
    for (int c = 1; c <= 10000; c++) begin
      if (ifA.MsTick) begin
        msCount++;
        if (firstMs == 0) firstMs = c;
      end
      if (ifA.SecTick) begin
        if (secQ.size() == 0) checkOutput("sectick_extra", c, 0);
        else checkOutput("sectick_cycle", c, secQ.pop_front());
      end
      @(negedge clk);
    end
    checkOutput("mstick_count", msCount, 2000);
    checkOutput("first_mstick", firstMs, 5);
    checkOutput("sectick_missing", secQ.size(), 0);

    // Stopwatch sequencing in stopwatch mode.
    applyStimulus("idle",          0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("idle_stop_ign", 0, 0, 0, 1, 0, 0, 0, 4'b0000);
    applyStimulus("idle_clr_ign",  0, 0, 0, 0, 1, 0, 0, 4'b0000);
    applyStimulus("idle_low",      0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("start_run",     0, 0, 1, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run_hold_btn",  0, 0, 0, 0, 0, 0, 0, 4'b1000);
    applyStimulus("stop_hold",     0, 0, 0, 1, 0, 0, 0, 4'b0000);
    applyStimulus("hold_low",      0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("hold_stop_ign", 0, 0, 0, 1, 0, 0, 0, 4'b0000);
    applyStimulus("hold_low2",     0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("hold_start",    0, 0, 1, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run_low",       0, 0, 0, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run_start_ign", 0, 0, 1, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run_low2",      0, 0, 0, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run_clear",     0, 0, 0, 0, 1, 0, 0, 4'b0100);
    applyStimulus("clear_once",    0, 0, 0, 0, 1, 0, 0, 4'b0000);
    applyStimulus("clear_low",     0, 0, 0, 0, 0, 0, 0, 4'b0000);

    // Coincident edges while running: clear wins.
    applyStimulus("start_again",   0, 0, 1, 0, 0, 0, 0, 4'b1000);
    applyStimulus("start_low",     0, 0, 0, 0, 0, 0, 0, 4'b1000);
    applyStimulus("all_edges",     0, 0, 1, 1, 1, 0, 0, 4'b0100);
    applyStimulus("all_low",       0, 0, 0, 0, 0, 0, 0, 4'b0000);

    // Clock mode masks stopwatch edges; clear from HOLD pulses SW_Clear.
    applyStimulus("ctrl_start_ign",  0, 1, 1, 0, 0, 0, 0, 4'b0001);
    applyStimulus("ctrl_back_held",  0, 0, 1, 0, 0, 0, 0, 4'b0000);
    applyStimulus("held_low",        0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("run3",            0, 0, 1, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run3_low",        0, 0, 0, 0, 0, 0, 0, 4'b1000);
    applyStimulus("hold3",           0, 0, 0, 1, 0, 0, 0, 4'b0000);
    applyStimulus("hold3_low",       0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("hold_clear",      0, 0, 0, 0, 1, 0, 0, 4'b0100);
    applyStimulus("hold_clear_low",  0, 0, 0, 0, 0, 0, 0, 4'b0000);
    applyStimulus("run4",            0, 0, 1, 0, 0, 0, 0, 4'b1000);
    applyStimulus("run4_low",        0, 0, 0, 0, 0, 0, 0, 4'b1000);
    applyStimulus("ctrl_keeps_run",  0, 1, 0, 0, 0, 0, 0, 4'b1001);

    // Alarm dismiss in clock mode versus stop in stopwatch mode.
    applyStimulus("ring_c1",         0, 1, 0, 0, 0, 1, 1, 4'b1011);
    applyStimulus("dismiss_c1",      0, 1, 0, 1, 0, 1, 1, 4'b1001);
    applyStimulus("dismiss_low",     0, 1, 0, 0, 0, 1, 1, 4'b1001);
    applyStimulus("match_low",       0, 1, 0, 0, 0, 1, 0, 4'b1001);
    applyStimulus("ring_c0",         0, 0, 0, 0, 0, 1, 1, 4'b1010);
    applyStimulus("stop_c0",         0, 0, 0, 1, 0, 1, 1, 4'b0010);
    applyStimulus("stop_c0_low",     0, 0, 0, 0, 0, 1, 1, 4'b0010);
    applyStimulus("disable_off",     0, 0, 0, 0, 0, 0, 1, 4'b0000);
    applyStimulus("disable_low",     0, 0, 0, 0, 0, 0, 0, 4'b0000);

    // Match rising while disarmed never rings, and arming later is not an edge.
    applyStimulus("match_disarmed",  0, 0, 0, 0, 0, 0, 1, 4'b0000);
    applyStimulus("arm_match_high",  0, 0, 0, 0, 0, 1, 1, 4'b0000);
    applyStimulus("arm_match_low",   0, 0, 0, 0, 0, 1, 0, 4'b0000);

    // Timed ring: exactly 60 second ticks while Alarm is high.
    applyStimulus("ring_timed",      0, 0, 0, 0, 0, 1, 1, 4'b0010);
    ringTicks = 0;
    n = 0;
    while (ifB.Alarm && n < 5000) begin
      if (ifB.SecTick) ringTicks++;
      @(negedge clk);
      n++;
    end
    checkOutput("ring_timeout", {31'd0, (n < 5000)}, 32'd1);
    checkOutput("ring_secticks", ringTicks, 60);
    for (int i = 0; i < 10; i++)
      applyStimulus("no_retrigger",  0, 0, 0, 0, 0, 1, 1, 4'b0000);
    applyStimulus("retrig_low",      0, 0, 0, 0, 0, 1, 0, 4'b0000);

    // Start held through reset stays idle; reset mid-run/mid-ring gives no clear pulse.
    applyStimulus("rst_start_held",  1, 0, 1, 0, 0, 1, 0, 4'b0000);
    applyStimulus("rel_start_held",  0, 0, 1, 0, 0, 1, 0, 4'b0000);
    applyStimulus("rel_start_low",   0, 0, 0, 0, 0, 1, 0, 4'b0000);
    applyStimulus("start_after_rst", 0, 0, 1, 0, 0, 1, 0, 4'b1000);
    applyStimulus("run5_low",        0, 0, 0, 0, 0, 1, 0, 4'b1000);
    applyStimulus("ring_in_run",     0, 0, 0, 0, 0, 1, 1, 4'b1010);
    applyStimulus("rst_mid_run",     1, 0, 0, 0, 0, 1, 1, 4'b0000);
    checkOutput("rst_ticks_zero", {30'd0, ifB.MsTick, ifB.SecTick}, 32'd0);

    driveInputs(1'b0, 0, 0, 0, 0, 1, 1);
    firstMs  = 0;
    firstSec = 0;
    for (int c = 1; c <= 30; c++) begin
      if (ifB.MsTick && firstMs == 0) firstMs = c;
      if (ifB.SecTick && firstSec == 0) firstSec = c;
      @(negedge clk);
    end
    checkOutput("rst_first_ms", firstMs, 5);
    checkOutput("rst_first_sec", firstSec, 20);
    checkOutput("rst_no_ring", {29'd0, ifB.SW_State, ifB.SW_Clear, ifB.Alarm}, 32'd0);

    applyStimulus("rst_disp_c1",     1, 1, 0, 0, 0, 0, 0, 4'b0001);
    applyStimulus("rst_disp_c0",     0, 0, 0, 0, 0, 0, 0, 4'b0000);

    if (sb.size() != 0) checkOutput("scoreboard_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_mode_controller.md
WATCH_MODE_CONTROLLER -- requirements
Module: watch_mode_controller

Interface
REQ-001 SHALL use a single clock domain; reset is synchronous and active-high.
REQ-002 Clock_5K  input  1  system clock, 5 kHz.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Control  input  1  mode select; 1 = clock/alarm mode, 0 = stopwatch mode.
REQ-005 Start_S, Stop_S, Reset_S  input  1 each  level stopwatch buttons, synchronous to Clock_5K.
REQ-006 AlarmEnable  input  1  alarm arm level.
REQ-007 AlarmMatch  input  1  level from timekeeper: time equals alarm time and seconds == 0.
REQ-008 MsTick  output  1  1-cycle pulse every 1 ms.
REQ-009 SecTick  output  1  1-cycle pulse every 1 s.
REQ-010 SW_Run  output  1  stopwatch count enable, qualified with MsTick by the datapath.
REQ-011 SW_Clear  output  1  1-cycle stopwatch clear pulse.
REQ-012 SW_State  output  1  high while the stopwatch FSM is in RUN.
REQ-013 Alarm  output  1  high while the alarm FSM is in RING.
REQ-014 DispSel  output  1  registered copy of Control; selects the display source.

Function
REQ-015 Prescaler: ms counter 0..4 SHALL increment every cycle; MsTick SHALL be high in the cycle the counter equals 4, then the counter wraps to 0.
REQ-016 Sec counter 0..999 SHALL advance on MsTick; SecTick SHALL be high when MsTick is high and the counter equals 999, then it wraps to 0; both counters SHALL be free-running in all modes.
REQ-017 Button edges: each button SHALL be registered once; edge = current & ~previous; SW FSM edges SHALL be honoured only when Control=0.
REQ-018 SW FSM states: IDLE, RUN, HOLD; edge priority Reset_S > Stop_S > Start_S when edges coincide.
REQ-019 IDLE: Start edge -> RUN; Stop and Reset edges ignored.
REQ-020 RUN: Reset edge -> IDLE with SW_Clear pulse; Stop edge -> HOLD; Start edge ignored.
REQ-021 HOLD: Reset edge -> IDLE with SW_Clear pulse; Start edge -> RUN; Stop edge ignored.
REQ-022 SW_Run SHALL be 1 only in RUN; SW_State = SW_Run; SW_Clear SHALL assert in the cycle after the qualifying Reset edge is sampled, for exactly 1 cycle.
REQ-023 A Control change SHALL NOT alter SW FSM state; the stopwatch keeps running while clock mode is displayed.
REQ-024 Alarm FSM states: OFF, RING; OFF -> RING on a rising edge of AlarmMatch while AlarmEnable=1; a level-high AlarmMatch SHALL NOT retrigger.
REQ-025 RING -> OFF on the first of: AlarmEnable=0; Stop_S edge while Control=1 (dismiss); 60 SecTicks counted in RING; the ring counter SHALL clear on entry to RING.
REQ-026 A Stop_S edge in Control=1 SHALL dismiss the alarm only and SHALL NOT affect the SW FSM.
REQ-027 If AlarmMatch rises while AlarmEnable=0, no RING SHALL occur.

Reset
REQ-028 Reset SHALL zero the ms, sec and ring counters and force the SW FSM to IDLE and the alarm FSM to OFF.
REQ-029 Reset SHALL drive all outputs to 0, except DispSel, which SHALL load Control.
REQ-030 Reset SHALL load the previous-value registers of the buttons and AlarmMatch to 1, so a level held through reset produces no edge.
REQ-031 Reset mid-RUN or mid-RING SHALL take effect on the next clock edge with no SW_Clear pulse.

Structure
REQ-032 Shared package watch_pkg SHALL hold the SW and alarm state encodings, CLK_PER_MS=5, MS_PER_SEC=1000 and RING_SECS=60.
REQ-033 One sub-module, edge_detect (1-bit rising-edge detector, reset-to-1 history), SHALL be instantiated 4 times.

Verification
REQ-034 Scenario: release Reset, run 10000 cycles -> exactly 2000 MsTick pulses, 2 SecTick pulses, first SecTick at cycle 5000 after reset release.
REQ-035 Scenario: Control=0; Start edge -> SW_State=1; Stop edge -> SW_State=0 (HOLD); Start edge -> 1; Reset edge -> one SW_Clear pulse, IDLE.
REQ-036 Scenario: Start_S, Stop_S and Reset_S rise in the same cycle while in RUN -> IDLE with SW_Clear, not HOLD.
REQ-037 Scenario: AlarmEnable=1, AlarmMatch rises and holds -> Alarm=1; Alarm falls after exactly 60 SecTicks; no retrigger while AlarmMatch stays high.
REQ-038 Scenario: RING with Control=1, Stop_S edge -> Alarm=0 next cycle, SW FSM unchanged; repeat with Control=0 -> Alarm stays 1, SW FSM acts.
REQ-039 Scenario: Start_S held high through Reset -> remains IDLE after release; Reset asserted mid-RUN -> IDLE, SW_Clear=0, counters 0.
